// File: rtl/nn_pkg.sv
// Shared definitions for the forward-propagation sequencer and its host-side reader.
package nn_pkg;

  localparam logic [2:0] LAYER_IDLE = 3'b000;
  localparam logic [2:0] LAYER_1    = 3'b001;
  localparam logic [2:0] LAYER_2    = 3'b010;
  localparam logic [2:0] LAYER_3    = 3'b100;

  localparam int NUM_CLASSES_DEFAULT = 10;
  localparam int SCORE_W_DEFAULT     = 16;
  localparam int TIMEOUT_DEFAULT     = 1023;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SCAN,
    RESULT
  } reader_state_t;

endpackage

// File: rtl/argmax_scan.sv
// Serial argmax unit: clear loads the first entry, step keeps the strictly greater signed value.
module argmax_scan #(
  parameter int SCORE_W = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_clear,
  input  logic                      i_step,
  input  logic signed [SCORE_W-1:0] i_value,
  input  logic [3:0]                i_index,
  output logic [3:0]                o_best_idx,
  output logic signed [SCORE_W-1:0] o_best_val
);

  logic [3:0]                r_best_idx;
  logic signed [SCORE_W-1:0] r_best_val;

  // Strict compare keeps the lowest index on ties.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_best_idx <= '0;
      r_best_val <= '0;
    end else if (i_clear) begin
      r_best_idx <= i_index;
      r_best_val <= i_value;
    end else if (i_step && (i_value > r_best_val)) begin
      r_best_idx <= i_index;
      r_best_val <= i_value;
    end
  end

  assign o_best_idx = r_best_idx;
  assign o_best_val = r_best_val;

endmodule

// File: rtl/nn_result_reader.sv
// Host-side reader: turns a Start edge into a Compute request, captures the final-layer
// scores on the layer-3 load strobe and reports their argmax as a digit.
module nn_result_reader
  import nn_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEFAULT,
  parameter int SCORE_W     = SCORE_W_DEFAULT,
  parameter int TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [2:0]                     i_layer,
  input  logic                           i_ld_io,
  input  logic [NUM_CLASSES*SCORE_W-1:0] i_scores,
  output logic                           o_compute,
  output logic                           o_busy,
  output logic                           o_valid,
  output logic [3:0]                     o_digit,
  output logic                           o_error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  reader_state_t             r_state, w_state_next;
  logic                      r_start_q;
  logic [TW-1:0]             r_timer;
  logic [3:0]                r_idx;
  logic [3:0]                r_digit;
  logic                      r_error;
  logic signed [SCORE_W-1:0] r_buf [NUM_CLASSES];

  logic                      w_start_rise;
  logic                      w_capture;
  logic                      w_timeout;
  logic                      w_last;
  logic [3:0]                w_best_idx;
  logic signed [SCORE_W-1:0] w_unused_best_val;

  assign w_start_rise = i_start & ~r_start_q;
  assign w_capture    = i_ld_io && (i_layer == LAYER_3);
  assign w_timeout    = (r_timer == TW'(TIMEOUT));
  assign w_last       = (r_idx == 4'(NUM_CLASSES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_rise) w_state_next = REQ;
      REQ: begin
        if (w_capture)      w_state_next = SCAN;
        else if (w_timeout) w_state_next = IDLE;
      end
      SCAN:    if (w_last) w_state_next = RESULT;
      RESULT:  if (w_start_rise) w_state_next = REQ;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_start_q <= 1'b0;
      r_timer   <= '0;
      r_idx     <= '0;
      r_digit   <= '0;
      r_error   <= 1'b0;
    end else begin
      r_start_q <= i_start;
      case (r_state)
        IDLE: begin
          if (w_start_rise) begin
            r_timer <= '0;
            r_error <= 1'b0;
          end
        end
        REQ: begin
          r_timer <= r_timer + TW'(1);
          if (!w_capture && w_timeout) r_error <= 1'b1;
        end
        SCAN: r_idx <= w_last ? 4'd0 : r_idx + 4'd1;
        RESULT: begin
          // Shadow copy so Digit survives the next scan overwriting the argmax unit.
          r_digit <= w_best_idx;
          if (w_start_rise) begin
            r_timer <= '0;
            r_error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Only the first layer-3 strobe is seen because REQ is left on that same edge.
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_buf
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                            r_buf[gi] <= '0;
      else if (r_state == REQ && w_capture) r_buf[gi] <= i_scores[gi*SCORE_W +: SCORE_W];
    end
  end

  argmax_scan #(.SCORE_W(SCORE_W)) u_argmax (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    ((r_state == SCAN) && (r_idx == 4'd0)),
    .i_step     (r_state == SCAN),
    .i_value    (r_buf[r_idx]),
    .i_index    (r_idx),
    .o_best_idx (w_best_idx),
    .o_best_val (w_unused_best_val)
  );

  assign o_compute = (r_state == REQ);
  assign o_busy    = (r_state == REQ) || (r_state == SCAN);
  assign o_valid   = (r_state == RESULT);
  assign o_digit   = (r_state == RESULT) ? w_best_idx : r_digit;
  assign o_error   = r_error;

endmodule

// File: tb/tb_nn_result_reader.sv
// Directed bench for nn_result_reader: request handshake, argmax, timeout and reset cases.
module tb_nn_result_reader;

  localparam int NC = 10;
  localparam int SW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       layer;
  logic             ld_io;
  logic [NC*SW-1:0] scores;
  logic             compute, busy, valid, error;
  logic [3:0]       digit;

  int n_checks = 0;
  int n_pass   = 0;
  int n_req    = 0;

  always #5 clk = ~clk;

  nn_result_reader #(.NUM_CLASSES(NC), .SCORE_W(SW), .TIMEOUT(1023)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_layer   (layer),
    .i_ld_io   (ld_io),
    .i_scores  (scores),
    .o_compute (compute),
    .o_busy    (busy),
    .o_valid   (valid),
    .o_digit   (digit),
    .o_error   (error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic capture(input logic [NC*SW-1:0] s);
    ld_io  = 1'b1;
    layer  = 3'b100;
    scores = s;
    tick();
    ld_io  = 1'b0;
    layer  = 3'b000;
  endtask

  function automatic logic [NC*SW-1:0] fill(input int base, input int hi, input int hv);
    logic [NC*SW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*SW +: SW] = (i == hi) ? SW'(hv) : SW'(base);
    return r;
  endfunction

  task automatic report();
    n_req++;
    $display("req %0d: valid=%0d digit=%0d error=%0d", n_req, valid, digit, error);
  endtask

  initial begin
    int               b[NC];
    int               lo;
    logic [NC*SW-1:0] s;

    rst = 1'b1; start = 1'b0; layer = 3'b000; ld_io = 1'b0; scores = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("reset_compute", 32'(compute), 32'd0);
    check_eq("reset_busy",    32'(busy),    32'd0);
    check_eq("reset_valid",   32'(valid),   32'd0);
    check_eq("reset_digit",   32'(digit),   32'd0);
    check_eq("reset_error",   32'(error),   32'd0);

    // Basic: capture at cycle 840, index 7 wins, -100 must not win as unsigned.
    b = '{5, -3, 12, 7, 0, 1, 2, 40, 9, -100};
    for (int i = 0; i < NC; i++) s[i*SW +: SW] = SW'(b[i]);
    pulse_start();
    check_eq("basic_compute_c1", 32'(compute), 32'd1);
    lo = 0;
    for (int c = 1; c < 840; c++) begin
      if (!compute) lo++;
      tick();
    end
    if (!compute) lo++;
    check_eq("basic_compute_low_cycles", 32'(lo), 32'd0);
    capture(s);
    check_eq("basic_compute_c841", 32'(compute), 32'd0);
    check_eq("basic_busy_scan",    32'(busy),    32'd1);
    repeat (9) tick();
    check_eq("basic_valid_cap10", 32'(valid), 32'd0);
    tick();
    check_eq("basic_valid_cap11", 32'(valid), 32'd1);
    check_eq("basic_digit",       32'(digit), 32'd7);
    check_eq("basic_busy_done",   32'(busy),  32'd0);
    report();

    // Re-request from RESULT: Valid drops, Digit holds 7 until the new result.
    repeat (3) tick();
    pulse_start();
    check_eq("rereq_valid",   32'(valid),   32'd0);
    check_eq("rereq_compute", 32'(compute), 32'd1);
    check_eq("rereq_digit_hold", 32'(digit), 32'd7);
    repeat (3) tick();
    s = fill(-2, 0, 300);
    s[9*SW +: SW] = 16'd299;
    capture(s);
    repeat (10) tick();
    check_eq("rereq_valid_done", 32'(valid), 32'd1);
    check_eq("rereq_digit",      32'(digit), 32'd0);
    report();

    // Tie among negatives: lowest index wins.
    pulse_start();
    s = fill(-8, 3, -1);
    s[6*SW +: SW] = 16'hFFFF;
    capture(s);
    repeat (10) tick();
    check_eq("tie_digit", 32'(digit), 32'd3);
    check_eq("tie_valid", 32'(valid), 32'd1);
    report();

    // Ignored events: wrong-layer strobes, repeated layer-3 strobes, Start during SCAN.
    pulse_start();
    ld_io = 1'b1; layer = 3'b001; scores = fill(0, 5, 100);
    tick();
    check_eq("ign_l1_compute", 32'(compute), 32'd1);
    layer = 3'b010;
    tick();
    check_eq("ign_l2_compute", 32'(compute), 32'd1);
    layer = 3'b100; scores = fill(1, 2, 50);
    tick();
    check_eq("ign_capture_compute", 32'(compute), 32'd0);
    scores = fill(1, 9, 900);
    tick();
    scores = fill(1, 8, 800);
    tick();
    scores = fill(1, 4, 400); start = 1'b1;
    tick();
    ld_io = 1'b0; layer = 3'b000; start = 1'b0;
    repeat (7) tick();
    check_eq("ign_valid", 32'(valid), 32'd1);
    check_eq("ign_digit", 32'(digit), 32'd2);
    report();
    repeat (5) tick();
    check_eq("ign_no_second_req", 32'(compute), 32'd0);
    check_eq("ign_valid_stays",   32'(valid),   32'd1);

    // Timeout: timer reaches 1023 in REQ cycle 1024.
    pulse_start();
    repeat (1023) tick();
    check_eq("to_compute_c1024", 32'(compute), 32'd1);
    check_eq("to_error_early",   32'(error),   32'd0);
    tick();
    check_eq("to_compute_c1025", 32'(compute), 32'd0);
    check_eq("to_error",         32'(error),   32'd1);
    check_eq("to_valid",         32'(valid),   32'd0);
    check_eq("to_busy",          32'(busy),    32'd0);
    check_eq("to_digit_hold",    32'(digit),   32'd2);
    report();
    repeat (4) tick();
    check_eq("to_error_sticky", 32'(error), 32'd1);
    pulse_start();
    check_eq("to_error_cleared", 32'(error),   32'd0);
    check_eq("to_restart",       32'(compute), 32'd1);

    // Async reset at scan index 4: outputs drop before the next edge.
    tick();
    capture(fill(0, 4, 20));
    repeat (4) tick();
    check_eq("ar_busy_before", 32'(busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("ar_compute", 32'(compute), 32'd0);
    check_eq("ar_busy",    32'(busy),    32'd0);
    check_eq("ar_valid",   32'(valid),   32'd0);
    check_eq("ar_digit",   32'(digit),   32'd0);
    tick();
    rst = 1'b0;
    repeat (12) tick();
    check_eq("ar_no_valid", 32'(valid), 32'd0);

    // Clean request after reset with Start held high: last index, extreme values.
    start = 1'b1;
    tick();
    check_eq("held_compute", 32'(compute), 32'd1);
    capture(fill(-32768, 9, 32767));
    repeat (10) tick();
    check_eq("held_valid", 32'(valid), 32'd1);
    check_eq("held_digit", 32'(digit), 32'd9);
    report();
    repeat (5) tick();
    check_eq("held_single_req", 32'(compute), 32'd0);
    start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nn_result_reader.md
Name: nn_result_reader

Overview:
- Host-side initiator and output consumer for the forward-propagation sequencer.
- Converts a user Start pulse or level into the sequencer's Compute request and holds Compute until the final layer's output load strobe.
- Captures the 10 final-layer scores, finds the argmax with a serial scan, and presents the classified digit with a Valid flag.
- Sits between the board I/O (button, hex display) and the sequencer/layer datapath.

Parameters:
- NUM_CLASSES, 10, number of final-layer neurons scanned.
- SCORE_W, 16, width of each signed two's-complement score.
- TIMEOUT, 1023, maximum cycles from Compute assertion to capture before the request is aborted.

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Start  in  1  user request, level; only a rising edge is acted on.
- Layer  in  3  one-hot active layer from the sequencer (001/010/100; 000 when idle or done).
- LD_IO  in  1  output-load strobe from the sequencer.
- Scores  in  NUM_CLASSES*SCORE_W  final-layer outputs, packed; index 0 in the LSBs.
- Compute  out  1  request to the sequencer.
- Busy  out  1  high from accepted Start until the result or an error.
- Valid  out  1  Digit holds a valid result.
- Digit  out  4  argmax index, 0..NUM_CLASSES-1.
- Error  out  1  sticky timeout flag.

Behaviour:
- Reset state: state=IDLE; Compute=0, Busy=0, Valid=0, Digit=0, Error=0; score buffer and counters cleared; Start edge-detect register cleared.
- Start edge: start_q registers Start; start_rise = Start & ~start_q.
- State IDLE:
  - On start_rise: go to REQ; clear Valid and Error; load timer with 0.
- State REQ:
  - Compute=1, Busy=1; timer increments each cycle.
  - On LD_IO=1 && Layer==3'b100: latch Scores into the internal buffer (first such cycle only), then go to SCAN.
  - Otherwise, if timer==TIMEOUT: go to IDLE, Error=1, Compute=0.
- State SCAN:
  - Compute=0. Dropping Compute lets the sequencer leave its DONE state.
  - Index idx runs 0..NUM_CLASSES-1, one entry per cycle.
  - best_val and best_idx are initialised from entry 0 at idx=0.
  - For each later idx, update only on a strictly greater signed compare. On a tie, the lowest index wins.
  - At idx==NUM_CLASSES-1: go to RESULT.
- State RESULT:
  - Digit=best_idx, Valid=1, Busy=0.
  - Stay until start_rise, which clears Valid and goes to REQ (same actions as from IDLE).
- Latency: Valid rises NUM_CLASSES+1 cycles after the capture cycle.
- Start edges while Busy=1 are ignored; no queueing.
- Start held high continuously produces exactly one request.
- LD_IO with Layer != 3'b100 is ignored in all states.
- LD_IO pulses after capture (the sequencer asserts the strobe for several cycles) are ignored.
- Reset asserted mid-REQ or mid-SCAN: Compute drops within the same cycle (async); no Valid is produced.
- Error stays set until the next accepted start_rise or Reset.
- Digit holds its last value when Valid=0; it is not cleared except by Reset.
- Arithmetic: compares are signed on SCORE_W bits. idx and Digit are 4 bits; NUM_CLASSES must be ≤16.
- Timer is $clog2(TIMEOUT+1) bits and must not wrap before the compare.

Decomposition:
- Shared nn_pkg holds:
  - LAYER_IDLE=3'b000, LAYER_1=3'b001, LAYER_2=3'b010, LAYER_3=3'b100 constants, also used by the sequencer;
  - NUM_CLASSES and SCORE_W defaults;
  - the reader state enum {IDLE, REQ, SCAN, RESULT}.
- One sub-module, argmax_scan: sequential compare unit with inputs clear/step/value/index and outputs best_idx/best_val. The top level owns the FSM, handshake, timer and buffer.

Test Plan:
- Basic: Reset, then a Start pulse. Model the sequencer asserting Layer=100 and LD_IO=1 at cycle 840 with Scores={5,-3,12,7,0,1,2,40,9,-100} (index 0 first) -> Compute high cycles 1..840 and low from 841; Valid=1 at capture+11; Digit=7.
- Tie and negatives: all scores=-8 except index 3 and index 6 both =-1 -> Digit=3.
- Timeout: Start pulse and no LD_IO for 1023 cycles -> Compute falls at timer==1023, Error=1, Valid=0, state IDLE. The next Start clears Error.
- Ignored events: LD_IO pulsed with Layer=001 and Layer=010, then four consecutive LD_IO cycles with Layer=100 carrying different Scores -> only the first 100-cycle Scores are used. Start pulses during SCAN produce no second request.
- Async reset mid-scan: Reset asserted between clock edges at idx=4 -> Compute, Busy and Valid are 0 before the next edge. After release, Start runs a clean request.
- Re-request: from RESULT with Digit=7, Start rising edge -> Valid=0 the next cycle, Compute=1. New scores with the maximum at index 0 -> Digit=0.
